// File: rtl/nbit_serial_subtractor.sv
// nbit_serial_subtractor: bit-serial unsigned A-B, LSB first, (N+1)-bit two's complement result
module nbit_serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   d,
  output logic         busy
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] sa, sb, res, res_n;
  logic [CW-1:0] cnt;
  logic br, di, br_n, last;
  assign di = sa[0] ^ sb[0] ^ br;
  assign br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res_n = (res >> 1) | (N'(di) << (N - 1));
  assign last = cnt == CW'(N - 1);
  assign in_ready = rst_n && state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = in_valid ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // d is only written on the final bit edge, so it never shows a partial result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
      d   <= '0;
    end else if (in_valid && in_ready) begin
      sa  <= a;
      sb  <= b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_n;
      cnt <= cnt + 1'b1;
      res <= res_n;
      if (last) d <= {br_n, res_n};
    end
endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// tb_nbit_serial_subtractor: directed N=4 checks plus a random sweep at N=1/4/8 against an arithmetic model
module tb_nbit_serial_subtractor;
  logic clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;

  logic rst_d = 0, iv_d = 0, or_d = 0, ir_d, ov_d, bz_d;
  logic [3:0] a_d = 0, b_d = 0;
  logic [4:0] d_d;
  nbit_serial_subtractor #(.N(4)) u_d (.clk(clk), .rst_n(rst_d), .in_valid(iv_d), .in_ready(ir_d),
    .a(a_d), .b(b_d), .out_valid(ov_d), .out_ready(or_d), .d(d_d), .busy(bz_d));

  logic rst_r = 0;
  logic iv1 = 0, iv4 = 0, iv8 = 0, or1 = 0, or4 = 0, or8 = 0;
  logic ir1, ir4, ir8, ov1, ov4, ov8, bz1, bz4, bz8;
  logic [0:0] a1 = 0, b1 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [1:0] d1;
  logic [4:0] d4;
  logic [8:0] d8;
  nbit_serial_subtractor #(.N(1)) u_1 (.clk(clk), .rst_n(rst_r), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .d(d1), .busy(bz1));
  nbit_serial_subtractor #(.N(4)) u_4 (.clk(clk), .rst_n(rst_r), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .d(d4), .busy(bz4));
  nbit_serial_subtractor #(.N(8)) u_8 (.clk(clk), .rst_n(rst_r), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .d(d8), .busy(bz8));

  int w[3] = '{1, 4, 8};
  int pend[3], since[3], expd[3], dlast[3];
  int ov[3], ir[3], bz[3], dd[3];
  int iv[3], av[3], bv[3], orv[3];

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic job(input int a, input int b, input int exp, input string name);
    @(negedge clk);
    chk({name, " in_ready"}, ir_d, 1);
    iv_d = 1; a_d = 4'(a); b_d = 4'(b); or_d = 1;
    @(negedge clk);
    iv_d = 0; a_d = 4'($urandom); b_d = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({name, " early out_valid"}, ov_d, 0);
      @(negedge clk);
    end
    chk({name, " out_valid"}, ov_d, 1);
    chk({name, " busy"}, bz_d, 1);
    chk({name, " d"}, d_d, exp);
    @(negedge clk);
    chk({name, " out_valid after accept"}, ov_d, 0);
    chk({name, " in_ready after accept"}, ir_d, 1);
    chk({name, " d retained"}, d_d, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset d", d_d, 0);
    chk("reset out_valid", ov_d, 0);
    chk("reset busy", bz_d, 0);
    chk("reset in_ready", ir_d, 0);
    rst_d = 1;
    @(negedge clk);
    chk("post-reset in_ready", ir_d, 1);
    chk("post-reset busy", bz_d, 0);
    job(9, 3, 'b00110, "9-3");
    job(3, 9, 'b11010, "3-9");
    job(0, 15, 'b10001, "0-15");
    job(0, 0, 0, "0-0");
    job(15, 15, 0, "15-15");
    // backpressure: held DONE ignores in_valid pulses
    @(negedge clk);
    iv_d = 1; a_d = 9; b_d = 3; or_d = 0;
    @(negedge clk);
    iv_d = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold out_valid", ov_d, 1);
      chk("hold d", d_d, 'b00110);
      chk("hold in_ready", ir_d, 0);
      chk("hold busy", bz_d, 1);
      iv_d = 1'(i); a_d = 4'($urandom); b_d = 4'($urandom);
      @(negedge clk);
    end
    iv_d = 0; or_d = 1;
    @(negedge clk);
    chk("release out_valid", ov_d, 0);
    chk("release in_ready", ir_d, 1);
    chk("release busy", bz_d, 0);
    chk("release d", d_d, 'b00110);
    // abort mid-RUN at cnt=2
    iv_d = 1; a_d = 15; b_d = 1;
    @(negedge clk);
    iv_d = 0;
    repeat (2) @(negedge clk);
    rst_d = 0;
    #1;
    chk("abort d", d_d, 0);
    chk("abort out_valid", ov_d, 0);
    chk("abort busy", bz_d, 0);
    chk("abort in_ready", ir_d, 0);
    @(negedge clk);
    rst_d = 1;
    job(7, 2, 'b00101, "7-2");

    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; since[k] = 0; expd[k] = 0; dlast[k] = 0;
    end
    @(negedge clk);
    rst_r = 1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      ov[0] = int'(ov1); ov[1] = int'(ov4); ov[2] = int'(ov8);
      ir[0] = int'(ir1); ir[1] = int'(ir4); ir[2] = int'(ir8);
      bz[0] = int'(bz1); bz[1] = int'(bz4); bz[2] = int'(bz8);
      dd[0] = int'(d1);  dd[1] = int'(d4);  dd[2] = int'(d8);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("N%0d in_ready", w[k]), ir[k], int'(pend[k] == 0));
        chk($sformatf("N%0d busy", w[k]), bz[k], pend[k]);
        chk($sformatf("N%0d out_valid", w[k]), ov[k], int'(pend[k] != 0 && since[k] >= w[k]));
        if (pend[k] != 0 && since[k] >= w[k]) chk($sformatf("N%0d d", w[k]), dd[k], expd[k]);
        else if (pend[k] == 0) chk($sformatf("N%0d idle d", w[k]), dd[k], dlast[k]);
        iv[k] = int'($urandom_range(0, 3) != 0);
        av[k] = int'($urandom_range(0, (1 << w[k]) - 1));
        bv[k] = int'($urandom_range(0, (1 << w[k]) - 1));
        orv[k] = int'($urandom_range(0, 2) != 0);
        if (pend[k] == 0 && iv[k] != 0) begin
          pend[k] = 1; since[k] = 0;
          expd[k] = (av[k] - bv[k]) & ((1 << (w[k] + 1)) - 1);
        end else if (pend[k] != 0) begin
          if (since[k] >= w[k] && orv[k] != 0) begin
            pend[k] = 0; dlast[k] = expd[k];
          end else since[k]++;
        end
      end
      iv1 = 1'(iv[0]); a1 = 1'(av[0]); b1 = 1'(bv[0]); or1 = 1'(orv[0]);
      iv4 = 1'(iv[1]); a4 = 4'(av[1]); b4 = 4'(bv[1]); or4 = 1'(orv[1]);
      iv8 = 1'(iv[2]); a8 = 8'(av[2]); b8 = 8'(bv[2]); or8 = 1'(orv[2]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
